operand_select_stage: RTL and testbench

- Registered operand-select stage between decode and ALU.
- Picks operand 1 from PC, forwarded or register rs1, or zero, and operand 2 from forwarded or register rs2, or the immediate.
- Resolves RAW hazards against NUM_FWD in-flight producers and stalls on load-use.
- Holds the result in a one-entry valid/ready pipeline register.

---
 rtl/operand_select_stage_pkg.sv | 43 ++++
 rtl/operand_select_stage_fwd_resolve.sv | 43 ++++
 rtl/operand_select_stage.sv | 130 +++++++++++++
 tb/tb_operand_select_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_select_stage_pkg.sv
// Shared definitions for the operand-select stage: RV32 base opcodes,
// the operand-1 source encoding and opcode-to-usage helpers.
// Optional build macro used by the stage: OPSEL_STALL_CNT_EN.
package operand_select_stage_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_PC   = 2'd1,
    SRC_ZERO = 2'd2
  } op1_src_e;

  // Operand-1 source for a given opcode.
  function automatic op1_src_e op1_src_of(input logic [6:0] opc);
    op1_src_e src;
    case (opc)
      JAL, AUIPC, BRANCH, JALR: src = SRC_PC;
      LUI:                      src = SRC_ZERO;
      default:                  src = SRC_REG;
    endcase
    return src;
  endfunction

  // rs1 is read only when operand 1 comes from the register path.
  function automatic logic uses_rs1(input logic [6:0] opc);
    return (op1_src_of(opc) == SRC_REG);
  endfunction

  // rs2 is read by register-register ops, branches (compare) and stores (data).
  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP) || (opc == BRANCH) || (opc == STORE);
  endfunction

endpackage

// File: rtl/operand_select_stage_fwd_resolve.sv
// Priority forwarding match for one source register. Index 0 is the
// youngest producer and wins over higher indices. x0 never forwards.
module fwd_resolve
  import operand_select_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [XLEN-1:0]           regval,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]           value,
  output logic                      busy
);

  logic [NUM_FWD-1:0] hit;

  // Per-producer address match.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      hit[i] = fwd_valid[i] && (fwd_rd[i*REG_AW +: REG_AW] == addr) && (addr != '0);
    end
  end

  // Walk from oldest to youngest so the lowest matching index is the one kept;
  // busy follows only the selected producer, so older busy matches are ignored.
  always_comb begin
    value = regval;
    busy  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        value = fwd_data[i*XLEN +: XLEN];
        busy  = fwd_busy[i];
      end
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// Registered operand-select stage between decode and ALU. Resolves RAW
// hazards against in-flight producers, stalls on load-use and holds the
// selected operands in a one-entry valid/ready register.
// Optional build macro: OPSEL_STALL_CNT_EN adds a saturating stall counter.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                opcode,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1value,
  input  logic [XLEN-1:0]           rs2value,
  input  logic [XLEN-1:0]           PC,
  input  logic [XLEN-1:0]           imm,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [6:0]                out_opcode,
  output logic [XLEN-1:0]           oprand_1,
  output logic [XLEN-1:0]           oprand_2
`ifdef OPSEL_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            hazard;
  logic            capture;
  op1_src_e        op1_src;
  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;

  fwd_resolve #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD),
    .REG_AW  (REG_AW)
  ) u_rs1 (
    .addr      (rs1_addr),
    .regval    (rs1value),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (rs1_res),
    .busy      (rs1_busy)
  );

  fwd_resolve #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD),
    .REG_AW  (REG_AW)
  ) u_rs2 (
    .addr      (rs2_addr),
    .regval    (rs2value),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (rs2_res),
    .busy      (rs2_busy)
  );

  // Operand muxing and hazard/handshake decode.
  always_comb begin
    op1_src = op1_src_of(opcode);
    case (op1_src)
      SRC_PC:   op1_next = PC;
      SRC_ZERO: op1_next = '0;
      default:  op1_next = rs1_res;
    endcase
    op2_next = (opcode == OP) ? rs2_res : imm;
    hazard   = (uses_rs1(opcode) && rs1_busy) || (uses_rs2(opcode) && rs2_busy);
    in_ready = !hazard && (!out_valid || out_ready);
    capture  = in_valid && in_ready && !flush;
  end

  // Output valid: flush kills, capture fills, a consumed entry drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data registers load only on capture so a stalled entry stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_opcode <= '0;
      oprand_1   <= '0;
      oprand_2   <= '0;
    end else if (capture) begin
      out_opcode <= opcode;
      oprand_1   <= op1_next;
      oprand_2   <= op2_next;
    end
  end

`ifdef OPSEL_STALL_CNT_EN
  // Count cycles where decode offers an instruction but a load-use blocks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_select_stage.sv
module tb_operand_select_stage;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int REG_AW  = 5;

  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_LUI    = 7'b0110111;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [6:0]                opcode;
  logic [REG_AW-1:0]         rs1_addr;
  logic [REG_AW-1:0]         rs2_addr;
  logic [XLEN-1:0]           rs1value;
  logic [XLEN-1:0]           rs2value;
  logic [XLEN-1:0]           PC;
  logic [XLEN-1:0]           imm;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_busy;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [6:0]                out_opcode;
  logic [XLEN-1:0]           oprand_1;
  logic [XLEN-1:0]           oprand_2;
`ifdef OPSEL_STALL_CNT_EN
  logic [31:0]               stall_cnt;
`endif

  int checks;
  int failures;

  operand_select_stage #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD),
    .REG_AW  (REG_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1value   (rs1value),
    .rs2value   (rs2value),
    .PC         (PC),
    .imm        (imm),
    .fwd_valid  (fwd_valid),
    .fwd_busy   (fwd_busy),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .oprand_1   (oprand_1),
    .oprand_2   (oprand_2)
`ifdef OPSEL_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    opcode    = C_OP_IMM;
    rs1_addr  = '0;
    rs2_addr  = '0;
    rs1value  = '0;
    rs2value  = '0;
    PC        = '0;
    imm       = '0;
    fwd_valid = '0;
    fwd_busy  = '0;
    fwd_rd    = '0;
    fwd_data  = '0;
    out_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_valid got=%0b exp=0", out_valid); failures++;
    end
    checks++;
    if (oprand_1 !== 32'd0 || oprand_2 !== 32'd0 || out_opcode !== 7'd0) begin
      $display("FAIL reset_data got op1=%h op2=%h opc=%h exp=0", oprand_1, oprand_2, out_opcode);
      failures++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; opcode = C_OP;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1value = 32'd5; rs2value = 32'd7;
    tick();
    checks++;
    if (out_valid !== 1'b1 || oprand_1 !== 32'd5 || oprand_2 !== 32'd7 || out_opcode !== C_OP) begin
      $display("FAIL basic_op got v=%0b op1=%h op2=%h opc=%h exp v=1 op1=5 op2=7 opc=%h",
               out_valid, oprand_1, oprand_2, out_opcode, C_OP);
      failures++;
    end
    @(negedge clk);
    idle_inputs();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain_valid got=%0b exp=0", out_valid); failures++;
    end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_OP;
    rs1_addr = 5'd3; rs2_addr = 5'd9; rs1value = 32'h11; rs2value = 32'h22;
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA};
    fwd_busy = 2'b10;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL older_busy_ignored in_ready got=%0b exp=1", in_ready); failures++;
    end
    tick();
    checks++;
    if (oprand_1 !== 32'hAA || oprand_2 !== 32'h22) begin
      $display("FAIL fwd_prio got op1=%h op2=%h exp op1=aa op2=22", oprand_1, oprand_2);
      failures++;
    end
    @(negedge clk);
    fwd_busy = 2'b00; fwd_valid = 2'b10;
    rs2_addr = 5'd3;
    tick();
    checks++;
    if (oprand_1 !== 32'hBB || oprand_2 !== 32'hBB) begin
      $display("FAIL fwd_idx1 got op1=%h op2=%h exp bb/bb", oprand_1, oprand_2);
      failures++;
    end
    @(negedge clk);
    fwd_valid = 2'b11; fwd_rd = {5'd0, 5'd0};
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    checks++;
    if (oprand_1 !== 32'h11 || oprand_2 !== 32'h22) begin
      $display("FAIL x0_no_fwd got op1=%h op2=%h exp 11/22", oprand_1, oprand_2);
      failures++;
    end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_pc_select();
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_JAL;
    PC = 32'h100; imm = 32'd8; rs1value = 32'h77;
    tick();
    checks++;
    if (oprand_1 !== 32'h100 || oprand_2 !== 32'd8 || out_opcode !== C_JAL) begin
      $display("FAIL jal got op1=%h op2=%h opc=%h exp 100/8", oprand_1, oprand_2, out_opcode);
      failures++;
    end
    @(negedge clk);
    opcode = C_LUI; imm = 32'h12345000;
    rs1_addr = 5'd4; fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd4}; fwd_busy = 2'b01;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL lui_no_hazard in_ready got=%0b exp=1", in_ready); failures++;
    end
    tick();
    checks++;
    if (oprand_1 !== 32'd0 || oprand_2 !== 32'h12345000) begin
      $display("FAIL lui got op1=%h op2=%h exp 0/12345000", oprand_1, oprand_2);
      failures++;
    end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_OP;
    rs1_addr = 5'd1; rs2_addr = 5'd4; rs1value = 32'h3; rs2value = 32'h44;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd4}; fwd_busy = 2'b01; fwd_data = {32'h0, 32'h99};
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL load_use_ready cycle=%0d got=%0b exp=0", c, in_ready); failures++;
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL load_use_nocap cycle=%0d got=%0b exp=0", c, out_valid); failures++;
      end
      @(negedge clk);
    end
    fwd_busy = 2'b00;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL load_use_release got=%0b exp=1", in_ready); failures++;
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || oprand_1 !== 32'h3 || oprand_2 !== 32'h99) begin
      $display("FAIL load_use_cap got v=%0b op1=%h op2=%h exp 1/3/99", out_valid, oprand_1, oprand_2);
      failures++;
    end
`ifdef OPSEL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd2) begin
      $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); failures++;
    end
`endif
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure_flush();
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_OP_IMM; rs1_addr = 5'd6; rs1value = 32'h55; imm = 32'h66;
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    rs1value = 32'hDEAD; imm = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_ready cycle=%0d got=%0b exp=0", c, in_ready); failures++;
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || oprand_1 !== 32'h55 || oprand_2 !== 32'h66) begin
        $display("FAIL bp_hold cycle=%0d got v=%0b op1=%h op2=%h exp 1/55/66",
                 c, out_valid, oprand_1, oprand_2);
        failures++;
      end
      @(negedge clk);
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || oprand_1 !== 32'h55 || oprand_2 !== 32'h66) begin
      $display("FAIL flush got v=%0b op1=%h op2=%h exp 0/55/66", out_valid, oprand_1, oprand_2);
      failures++;
    end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1;
    logic [31:0] exp2;
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_OP_IMM; rs1_addr = 5'd7;
    for (int k = 1; k <= 4; k++) begin
      rs1value = 32'(10 * k);
      imm      = 32'(k);
      exp1     = 32'(10 * k);
      exp2     = 32'(k);
      tick();
      checks++;
      if (out_valid !== 1'b1 || oprand_1 !== exp1 || oprand_2 !== exp2) begin
        $display("FAIL b2b item=%0d got v=%0b op1=%h op2=%h exp 1/%h/%h",
                 k, out_valid, oprand_1, oprand_2, exp1, exp2);
        failures++;
      end
      @(negedge clk);
    end
    idle_inputs();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_drain got=%0b exp=0", out_valid); failures++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; opcode = C_OP_IMM; rs1value = 32'h123; imm = 32'h456; out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || oprand_1 !== 32'd0 || oprand_2 !== 32'd0) begin
      $display("FAIL reset_mid got v=%0b op1=%h op2=%h exp 0/0/0", out_valid, oprand_1, oprand_2);
      failures++;
    end
`ifdef OPSEL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      $display("FAIL stall_cnt_reset got=%0d exp=0", stall_cnt); failures++;
    end
`endif
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_fwd_priority();
    test_pc_select();
    test_load_use();
    test_backpressure_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
